// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM encoding,
// request codes and the number of bytes per core word.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [1:0] REQ_NONE  = 2'b00;
    localparam logic [1:0] REQ_LOAD  = 2'b01;
    localparam logic [1:0] REQ_STORE = 2'b10;

    localparam int BYTES = 4;

    // Last byte-counter value of each access; a load needs one extra cycle
    // because the RAM returns data one cycle after the address.
    localparam logic [2:0] RD_LAST = 3'd4;
    localparam logic [2:0] WR_LAST = 3'd3;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte lane helpers: insert a byte into a word at a lane, and extract the
// byte at a lane of another word. Purely combinational.
module mem_byte_lane
    import mem_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic [LEN-1:0] ins_word,
    input  logic [1:0]     ins_lane,
    input  logic [7:0]     ins_byte,
    output logic [LEN-1:0] ins_result,
    input  logic [LEN-1:0] ext_word,
    input  logic [1:0]     ext_lane,
    output logic [7:0]     ext_byte
);

    always_comb begin
        ins_result = ins_word;
        ext_byte   = 8'd0;
        for (int i = 0; i < BYTES; i++) begin
            if (ins_lane == i[1:0]) ins_result[8*i +: 8] = ins_byte;
            if (ext_lane == i[1:0]) ext_byte = ext_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Word-to-byte memory controller: one core word load/store becomes four
// single-byte RAM accesses, little-endian. Optional macro MEM_CTRL_ALIGN_CHECK_EN.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int LEN        = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    input  logic [1:0]            req_state,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [LEN-1:0]        core_wdata,
    output logic [LEN-1:0]        core_rdata,
    output logic                  done,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic                  ram_wr,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    // Handshake: a request is taken in IDLE when req_state is LOAD/STORE,
    // done is low and rdy_in is high; done pulses for one active cycle.
    state_t                state, state_n;
    logic [2:0]            cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] base, base_n;
    logic [LEN-1:0]        wdata, wdata_n;
    logic [LEN-1:0]        rbuf, rbuf_n;
    logic [LEN-1:0]        rdata_n;
    logic                  done_n;
    logic                  act_q;
    logic [7:0]            din_q;
    logic [7:0]            rd_byte;
    logic                  want;
    logic                  misaligned;
    logic [1:0]            offset;
    logic [LEN-1:0]        ins_result;
    logic [7:0]            ext_byte;

    assign want = (req_state == REQ_LOAD) || (req_state == REQ_STORE);

    // The RAM keeps reading through a stall, so the byte answering the last
    // active address is parked in din_q until the controller resumes.
    assign rd_byte = act_q ? ram_din : din_q;

    assign offset    = (cnt == RD_LAST) ? 2'd3 : cnt[1:0];
    assign busy      = (state == RD) || (state == WR);
    assign ram_addr  = busy ? base + ADDR_WIDTH'(offset) : '0;
    assign ram_wr    = (state == WR) && rdy_in;
    assign ram_dout  = (state == WR) ? ext_byte : 8'd0;
    assign dbg_state = state;

    mem_byte_lane #(.LEN(LEN)) u_lane (
        .ins_word   (rbuf),
        .ins_lane   (cnt[1:0] - 2'd1),
        .ins_byte   (rd_byte),
        .ins_result (ins_result),
        .ext_word   (wdata),
        .ext_lane   (cnt[1:0]),
        .ext_byte   (ext_byte)
    );

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned = |core_addr[1:0];
    assign err        = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        err_q <= 1'b0;
        else if (rdy_in) err_q <= (state == IDLE) && want && !done && misaligned;
    end
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        base_n  = base;
        wdata_n = wdata;
        rbuf_n  = rbuf;
        rdata_n = core_rdata;
        done_n  = done;
        if (rdy_in) begin
            done_n = 1'b0;
            case (state)
                IDLE: begin
                    if (want && !done) begin
                        if (misaligned) begin
                            done_n = 1'b1;
                        end else begin
                            base_n  = core_addr;
                            wdata_n = core_wdata;
                            cnt_n   = 3'd0;
                            state_n = (req_state == REQ_LOAD) ? RD : WR;
                        end
                    end
                end
                RD: begin
                    if (cnt != 3'd0) rbuf_n = ins_result;
                    if (cnt == RD_LAST) begin
                        rdata_n = ins_result;
                        done_n  = 1'b1;
                        cnt_n   = 3'd0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 3'd1;
                    end
                end
                WR: begin
                    if (cnt == WR_LAST) begin
                        done_n  = 1'b1;
                        cnt_n   = 3'd0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 3'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            base       <= '0;
            wdata      <= '0;
            rbuf       <= '0;
            core_rdata <= '0;
            done       <= 1'b0;
            act_q      <= 1'b0;
            din_q      <= 8'd0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            base       <= base_n;
            wdata      <= wdata_n;
            rbuf       <= rbuf_n;
            core_rdata <= rdata_n;
            done       <= done_n;
            act_q      <= rdy_in;
            if (act_q) din_q <= ram_din;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, word-level reference
// memory, randomized loads/stores with stalls, reset and back-to-back cases.
module tb_mem_ctrl;

    localparam int AW    = 17;
    localparam int LEN   = 32;
    localparam int DEPTH = 1 << AW;

    logic            clk;
    logic            rst;
    logic            rdy_in;
    logic [1:0]      req_state;
    logic [AW-1:0]   core_addr;
    logic [LEN-1:0]  core_wdata;
    logic [LEN-1:0]  core_rdata;
    logic            done;
    logic            busy;
    logic [AW-1:0]   ram_addr;
    logic [7:0]      ram_din;
    logic [7:0]      ram_dout;
    logic            ram_wr;
    logic            err;
    logic [1:0]      dbg_state;

    logic [7:0]      ram_mem [DEPTH];
    logic [7:0]      ref_mem [DEPTH];
    logic [24:0]     wr_log[$];
    logic [24:0]     exp_q[$];
    logic [AW-1:0]   got_addr_q[$];
    logic [AW-1:0]   exp_addr_q[$];
    logic [LEN-1:0]  exp_rdata;
    logic            err_seen;
    int              n_checks;
    int              n_errors;

    mem_ctrl #(.LEN(LEN), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy_in     (rdy_in),
        .req_state  (req_state),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .done       (done),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .ram_wr     (ram_wr),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- RAM model: 1-cycle read latency, logs committed writes
    always @(posedge clk) begin
        ram_din <= ram_mem[ram_addr];
        if (ram_wr) begin
            ram_mem[ram_addr] = ram_dout;
            wr_log.push_back({ram_addr, ram_dout});
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [LEN-1:0] ref_load(input logic [AW-1:0] a);
        logic [LEN-1:0] r;
        logic [AW-1:0]  ai;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            ai = a + AW'(i);
            r[8*i +: 8] = ref_mem[ai];
        end
        return r;
    endfunction

    task automatic ref_store(input logic [AW-1:0] a, input logic [LEN-1:0] wd);
        logic [AW-1:0] ai;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            ai = a + AW'(i);
            ref_mem[ai] = wd[8*i +: 8];
            exp_q.push_back({ai, wd[8*i +: 8]});
        end
    endtask

    // Byte addresses a load presents, one per cycle; a stalled cycle repeats.
    task automatic ref_addr_seq(input logic [AW-1:0] a, input int stall_at, input int stall_len);
        logic [AW-1:0] ai;
        exp_addr_q.delete();
        for (int c = 0; c < 5; c++) begin
            ai = a + AW'((c < 3) ? c : 3);
            exp_addr_q.push_back(ai);
            if (c == stall_at)
                for (int s = 0; s < stall_len; s++) exp_addr_q.push_back(ai);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one request, scrambles request inputs while busy, optionally
    // drops rdy_in for stall_len edges at byte step stall_at (-1: none).
    task automatic access(input logic [1:0] op, input logic [AW-1:0] a, input logic [LEN-1:0] wd,
                          input int stall_at, input int stall_len, output int done_k);
        got_addr_q.delete();
        wr_log.delete();
        @(negedge clk);
        req_state  = op;
        core_addr  = a;
        core_wdata = wd;
        rdy_in     = 1'b1;
        done_k     = 0;
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            @(negedge clk);
            if (busy) got_addr_q.push_back(ram_addr);
            if (err) err_seen = 1'b1;
            req_state  = 2'($urandom);
            core_addr  = AW'($urandom);
            core_wdata = $urandom;
            if (done) begin
                done_k    = k;
                req_state = 2'b00;
            end
            if (stall_at >= 0 && k == stall_at + 1) rdy_in = 1'b0;
            if (stall_at >= 0 && k == stall_at + 1 + stall_len) rdy_in = 1'b1;
        end
        req_state = 2'b00;
        rdy_in    = 1'b1;
        if (done_k == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL access_timeout: no done within 40 cycles for op %b addr %h", op, a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst        = 1'b0;
        rdy_in     = 1'b1;
        req_state  = 2'b01;
        core_addr  = 17'h00040;
        core_wdata = 32'h12345678;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, err, ram_wr} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: busy/done/err/wr got %b expected 0000", {busy, done, err, ram_wr});
        end
        n_checks++;
        if (core_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", core_rdata);
        end
        n_checks++;
        if ({ram_addr, ram_dout} !== 25'h0) begin
            n_errors++;
            $display("FAIL reset_ram_out: addr %h dout %h expected 0", ram_addr, ram_dout);
        end
        req_state = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, ram_wr, ram_addr, ram_dout} !== 28'h0) begin
            n_errors++;
            $display("FAIL idle_outputs: busy %b done %b wr %b addr %h dout %h expected all 0",
                     busy, done, ram_wr, ram_addr, ram_dout);
        end
        exp_rdata = '0;
    endtask

    task automatic test_load_basic();
        int k;
        logic [LEN-1:0] want_word;
        ram_mem[17'h00100] = 8'h11; ref_mem[17'h00100] = 8'h11;
        ram_mem[17'h00101] = 8'h22; ref_mem[17'h00101] = 8'h22;
        ram_mem[17'h00102] = 8'h33; ref_mem[17'h00102] = 8'h33;
        ram_mem[17'h00103] = 8'h44; ref_mem[17'h00103] = 8'h44;
        want_word = 32'h44332211;
        ref_addr_seq(17'h00100, -1, 0);
        access(2'b01, 17'h00100, '0, -1, 0, k);
        n_checks++;
        if (k !== 6) begin
            n_errors++;
            $display("FAIL load_latency: done after %0d cycles expected 6", k);
        end
        n_checks++;
        if (core_rdata !== want_word) begin
            n_errors++;
            $display("FAIL load_data: got %h expected %h", core_rdata, want_word);
        end
        exp_rdata = want_word;
        n_checks++;
        if (got_addr_q.size() != exp_addr_q.size()) begin
            n_errors++;
            $display("FAIL load_addr_count: got %0d expected %0d", got_addr_q.size(), exp_addr_q.size());
        end else begin
            for (int i = 0; i < exp_addr_q.size(); i++) begin
                n_checks++;
                if (got_addr_q[i] !== exp_addr_q[i]) begin
                    n_errors++;
                    $display("FAIL load_addr[%0d]: got %h expected %h", i, got_addr_q[i], exp_addr_q[i]);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL done_width: done got %b expected 0 one cycle after pulse", done);
        end
    endtask

    task automatic test_store();
        int k;
        ref_store(17'h00200, 32'hDEADBEEF);
        access(2'b10, 17'h00200, 32'hDEADBEEF, -1, 0, k);
        n_checks++;
        if (k !== 5) begin
            n_errors++;
            $display("FAIL store_latency: done after %0d cycles expected 5", k);
        end
        n_checks++;
        if (wr_log.size() != 4) begin
            n_errors++;
            $display("FAIL store_count: got %0d writes expected 4", wr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (wr_log[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL store_write[%0d]: got %h expected %h", i, wr_log[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (core_rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL store_keeps_rdata: got %h expected %h", core_rdata, exp_rdata);
        end
        access(2'b01, 17'h00200, '0, -1, 0, k);
        n_checks++;
        if (core_rdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL store_readback: got %h expected deadbeef", core_rdata);
        end
        exp_rdata = 32'hDEADBEEF;
    endtask

`ifndef MEM_CTRL_ALIGN_CHECK_EN
    task automatic test_wrap();
        int k;
        ref_addr_seq(17'h1FFFF, -1, 0);
        access(2'b01, 17'h1FFFF, '0, -1, 0, k);
        exp_rdata = ref_load(17'h1FFFF);
        n_checks++;
        if (core_rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL wrap_data: got %h expected %h", core_rdata, exp_rdata);
        end
        n_checks++;
        if (got_addr_q.size() != 5) begin
            n_errors++;
            $display("FAIL wrap_addr_count: got %0d expected 5", got_addr_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got_addr_q[i] !== exp_addr_q[i]) begin
                    n_errors++;
                    $display("FAIL wrap_addr[%0d]: got %h expected %h", i, got_addr_q[i], exp_addr_q[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_stall();
        int k;
        logic [LEN-1:0] wd;
        ref_addr_seq(17'h00300, 2, 3);
        access(2'b01, 17'h00300, '0, 2, 3, k);
        exp_rdata = ref_load(17'h00300);
        n_checks++;
        if (k !== 9) begin
            n_errors++;
            $display("FAIL stall_load_latency: done after %0d cycles expected 9", k);
        end
        n_checks++;
        if (core_rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL stall_load_data: got %h expected %h", core_rdata, exp_rdata);
        end
        n_checks++;
        if (got_addr_q != exp_addr_q) begin
            n_errors++;
            $display("FAIL stall_addr_seq: got %0d addresses, expected %0d with base+2 repeated",
                     got_addr_q.size(), exp_addr_q.size());
        end
        wd = $urandom;
        ref_store(17'h00400, wd);
        access(2'b10, 17'h00400, wd, 1, 2, k);
        n_checks++;
        if (k !== 7) begin
            n_errors++;
            $display("FAIL stall_store_latency: done after %0d cycles expected 7", k);
        end
        n_checks++;
        if (wr_log != exp_q) begin
            n_errors++;
            $display("FAIL stall_store_writes: got %0d writes, expected %0d", wr_log.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        int k;
        int stall_at;
        int stall_len;
        bit is_load;
        logic [AW-1:0]  a;
        logic [LEN-1:0] wd;
        err_seen = 1'b0;
        for (int it = 0; it < 16; it++) begin
            is_load = 1'($urandom_range(0, 1));
            a       = AW'($urandom);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
            a[1:0]  = 2'b00;
`endif
            wd        = $urandom;
            stall_at  = int'($urandom_range(0, is_load ? 5 : 4)) - 1;
            stall_len = int'($urandom_range(1, 3));
            if (is_load) begin
                ref_addr_seq(a, stall_at, stall_len);
                access(2'b01, a, wd, stall_at, stall_len, k);
                exp_rdata = ref_load(a);
                n_checks++;
                if (k !== 6 + ((stall_at >= 0) ? stall_len : 0)) begin
                    n_errors++;
                    $display("FAIL rand_load_latency[%0d]: got %0d stall %0d/%0d", it, k, stall_at, stall_len);
                end
                n_checks++;
                if (core_rdata !== exp_rdata) begin
                    n_errors++;
                    $display("FAIL rand_load_data[%0d]: addr %h got %h expected %h", it, a, core_rdata, exp_rdata);
                end
                n_checks++;
                if (got_addr_q != exp_addr_q) begin
                    n_errors++;
                    $display("FAIL rand_load_addr[%0d]: addr %h sequence differs (got %0d entries expected %0d)",
                             it, a, got_addr_q.size(), exp_addr_q.size());
                end
            end else begin
                ref_store(a, wd);
                access(2'b10, a, wd, stall_at, stall_len, k);
                n_checks++;
                if (k !== 5 + ((stall_at >= 0) ? stall_len : 0)) begin
                    n_errors++;
                    $display("FAIL rand_store_latency[%0d]: got %0d stall %0d/%0d", it, k, stall_at, stall_len);
                end
                n_checks++;
                if (wr_log != exp_q) begin
                    n_errors++;
                    $display("FAIL rand_store_writes[%0d]: addr %h data %h, got %0d writes", it, a, wd, wr_log.size());
                end
                n_checks++;
                if (core_rdata !== exp_rdata) begin
                    n_errors++;
                    $display("FAIL rand_store_rdata[%0d]: got %h expected %h", it, core_rdata, exp_rdata);
                end
            end
        end
        n_checks++;
        if (err_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL rand_err: err got 1 expected 0 on aligned/unchecked accesses");
        end
    endtask

    task automatic test_back_to_back();
        int dk[$];
        logic [AW-1:0]  a;
        logic [LEN-1:0] w;
        logic [24:0]    e;
        a = 17'h00600;
        w = $urandom;
        wr_log.delete();
        @(negedge clk);
        req_state  = 2'b10;
        core_addr  = a;
        core_wdata = w;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) dk.push_back(k);
        end
        req_state = 2'b00;
        repeat (8) @(negedge clk);
        ref_store(a, w);
        n_checks++;
        if (dk.size() != 3) begin
            n_errors++;
            $display("FAIL b2b_done_count: got %0d pulses expected 3", dk.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (dk[i] !== 5 + 6 * i) begin
                    n_errors++;
                    $display("FAIL b2b_done_cycle[%0d]: got %0d expected %0d", i, dk[i], 5 + 6 * i);
                end
            end
        end
        n_checks++;
        if (wr_log.size() != 16) begin
            n_errors++;
            $display("FAIL b2b_write_count: got %0d expected 16", wr_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = exp_q[i % 4];
                n_checks++;
                if (wr_log[i] !== e) begin
                    n_errors++;
                    $display("FAIL b2b_write[%0d]: got %h expected %h", i, wr_log[i], e);
                end
            end
        end
        n_checks++;
        if (core_rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL b2b_rdata: got %h expected %h", core_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int j;
        int k;
        logic [AW-1:0]  a;
        logic [AW-1:0]  b;
        logic [LEN-1:0] wd;
        logic [LEN-1:0] d2;
        a  = 17'h00700;
        b  = 17'h00800;
        wd = $urandom;
        d2 = $urandom;
        wr_log.delete();
        @(negedge clk);
        req_state  = 2'b10;
        core_addr  = a;
        core_wdata = wd;
        @(negedge clk);
        core_addr  = b;
        core_wdata = d2;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, ram_wr, done, ram_addr, ram_dout} !== 28'h0) begin
            n_errors++;
            $display("FAIL midreset_outputs: busy %b wr %b done %b addr %h dout %h expected all 0",
                     busy, ram_wr, done, ram_addr, ram_dout);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_done: got %b expected 0", done);
        end
        rst = 1'b1;
        j = 0;
        for (int i = 1; i <= 12 && j == 0; i++) begin
            @(negedge clk);
            if (done) j = i;
        end
        req_state = 2'b00;
        n_checks++;
        if (j !== 5) begin
            n_errors++;
            $display("FAIL midreset_held_req: done after %0d cycles expected 5", j);
        end
        ref_mem[a] = wd[7:0];
        ref_store(b, d2);
        exp_q.push_front({a, wd[7:0]});
        n_checks++;
        if (wr_log != exp_q) begin
            n_errors++;
            $display("FAIL midreset_writes: got %0d writes expected %0d", wr_log.size(), exp_q.size());
        end
        access(2'b01, a, '0, -1, 0, k);
        exp_rdata = ref_load(a);
        n_checks++;
        if (core_rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL midreset_partial: got %h expected %h", core_rdata, exp_rdata);
        end
    endtask

    task automatic test_align();
`ifdef MEM_CTRL_ALIGN_CHECK_EN
        for (int t = 0; t < 2; t++) begin
            wr_log.delete();
            @(negedge clk);
            req_state  = (t == 0) ? 2'b01 : 2'b10;
            core_addr  = (t == 0) ? 17'h00102 : 17'h00201;
            core_wdata = $urandom;
            @(negedge clk);
            n_checks++;
            if ({done, err, busy} !== 3'b110) begin
                n_errors++;
                $display("FAIL align_pulse[%0d]: done/err/busy got %b expected 110", t, {done, err, busy});
            end
            req_state = 2'b00;
            @(negedge clk);
            n_checks++;
            if ({done, err, busy} !== 3'b000) begin
                n_errors++;
                $display("FAIL align_clear[%0d]: done/err/busy got %b expected 000", t, {done, err, busy});
            end
            n_checks++;
            if (wr_log.size() != 0 || core_rdata !== exp_rdata) begin
                n_errors++;
                $display("FAIL align_no_access[%0d]: writes %0d rdata %h expected 0 writes rdata %h",
                         t, wr_log.size(), core_rdata, exp_rdata);
            end
        end
`else
        int k;
        err_seen = 1'b0;
        access(2'b01, 17'h00102, '0, -1, 0, k);
        exp_rdata = ref_load(17'h00102);
        n_checks++;
        if (k !== 6) begin
            n_errors++;
            $display("FAIL unaligned_latency: got %0d expected 6", k);
        end
        n_checks++;
        if (core_rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL unaligned_data: got %h expected %h", core_rdata, exp_rdata);
        end
        n_checks++;
        if (err_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL unaligned_err: err got 1 expected 0");
        end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        logic [7:0] b;
        clk        = 1'b0;
        rst        = 1'b0;
        rdy_in     = 1'b1;
        req_state  = 2'b00;
        core_addr  = '0;
        core_wdata = '0;
        ram_din    = 8'h00;
        n_checks   = 0;
        n_errors   = 0;
        err_seen   = 1'b0;
        exp_rdata  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            b          = 8'($urandom);
            ram_mem[i] = b;
            ref_mem[i] = b;
        end
        test_reset();
        test_load_basic();
        test_store();
`ifndef MEM_CTRL_ALIGN_CHECK_EN
        test_wrap();
`endif
        test_stall();
        test_align();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
